// File: rtl/jtkunio_pkg.sv
// Constants and helpers shared by the colour mixer and its bench.
// The palette index map and the transparency test are defined here.
package jtkunio_pkg;

   localparam logic [7:0] OBJ_BASE = 8'h80;
   localparam logic [7:0] BACKDROP = 8'h00;
   localparam int         COL_W    = 3;
   localparam int         LANE_BIT = 8;

   typedef struct packed {
      logic [3:0] red;
      logic [3:0] green;
      logic [3:0] blue;
   } rgb_t;

   // A pixel shows only when its layer is enabled and its colour is non-zero.
   function automatic logic opaque(input logic [COL_W-1:0] col, input logic en);
      return en & (|col);
   endfunction

endpackage

// File: rtl/jtkunio_colmix_if.sv
// CPU-side palette bus of the colour mixer.
interface jtkunio_colmix_if;
   logic [8:0] cpu_addr;
   logic       pal_cs;
   logic       cpu_wrn;
   logic [7:0] cpu_dout;
   logic [7:0] cpu_din;

   modport master (output cpu_addr, pal_cs, cpu_wrn, cpu_dout, input cpu_din);
   modport slave  (input cpu_addr, pal_cs, cpu_wrn, cpu_dout, output cpu_din);
endinterface

// File: rtl/jtframe_dual_ram16.sv
// Two-lane dual-port RAM: port 0 read/write with per-lane write enables,
// port 1 read-only with clock enable. Reads are registered and read-first.
module jtframe_dual_ram16 #(
   parameter int aw = 8,
   parameter int hw = 8
) (
   input  logic           clk,
   input  logic [aw-1:0]  addr0,
   input  logic [7+hw:0]  data0,
   input  logic [1:0]     we0,
   output logic [7+hw:0]  q0,
   input  logic [aw-1:0]  addr1,
   input  logic           ce1,
   output logic [7+hw:0]  q1
);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         localparam int LW  = (gi == 0) ? 8 : hw;
         localparam int LSB = gi * 8;

         logic [LW-1:0] mem [2**aw];
         logic [LW-1:0] q0_q;
         logic [LW-1:0] q1_q;

         always_ff @(posedge clk) begin
            if (we0[gi]) mem[addr0] <= data0[LSB +: LW];
            q0_q <= mem[addr0];
            if (ce1) q1_q <= mem[addr1];
         end

         assign q0[LSB +: LW] = q0_q;
         assign q1[LSB +: LW] = q1_q;
      end
   endgenerate

endmodule

// File: rtl/jtkunio_colmix.sv
// Final pixel stage: scroll/object priority, palette lookup and blank
// alignment, with a CPU port into the 256x12 palette.
module jtkunio_colmix
   import jtkunio_pkg::*;
#(
   parameter int BLANK_DLY = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pxl_cen,
   input  logic                LHBL,
   input  logic                LVBL,
   input  logic [5:0]          scr_pxl,
   input  logic [6:0]          obj_pxl,
   jtkunio_colmix_if.slave     cpu,
   input  logic [1:0]          gfx_en,
   output logic [3:0]          red,
   output logic [3:0]          green,
   output logic [3:0]          blue,
   output logic                LHBL_dly,
   output logic                LVBL_dly
);

   // The palette read register supplies the last stage, so the index chain
   // is one stage shorter than the blank chain.
   localparam int IDX_STAGES = BLANK_DLY - 1;

   logic [7:0]           idx_q [IDX_STAGES];
   logic [7:0]           idx_d [IDX_STAGES];
   logic [BLANK_DLY-1:0] lhbl_q, lhbl_d;
   logic [BLANK_DLY-1:0] lvbl_q, lvbl_d;
   logic                 lane_q, lane_d;
   logic [7:0]           pix_idx;
   logic [1:0]           cpu_we;
   logic [11:0]          cpu_q;
   logic [11:0]          scan_q;
   rgb_t                 rgb;

   always_comb begin
      pix_idx = BACKDROP;
      if (opaque(obj_pxl[COL_W-1:0], gfx_en[1]))
         pix_idx = OBJ_BASE | {1'b0, obj_pxl};
      else if (opaque(scr_pxl[COL_W-1:0], gfx_en[0]))
         pix_idx = {2'b00, scr_pxl};
   end

   always_comb begin
      idx_d  = idx_q;
      lhbl_d = lhbl_q;
      lvbl_d = lvbl_q;
      lane_d = cpu.cpu_addr[LANE_BIT];
      if (pxl_cen) begin
         idx_d[0] = pix_idx;
         for (int i = 1; i < IDX_STAGES; i++) idx_d[i] = idx_q[i-1];
         lhbl_d = {lhbl_q[BLANK_DLY-2:0], LHBL};
         lvbl_d = {lvbl_q[BLANK_DLY-2:0], LVBL};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < IDX_STAGES; i++) idx_q[i] <= '0;
         lhbl_q <= '0;
         lvbl_q <= '0;
         lane_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         lhbl_q <= lhbl_d;
         lvbl_q <= lvbl_d;
         lane_q <= lane_d;
      end
   end

   assign cpu_we = {2{cpu.pal_cs & ~cpu.cpu_wrn}}
                 & {cpu.cpu_addr[LANE_BIT], ~cpu.cpu_addr[LANE_BIT]};

   // Hi lane keeps only the blue nibble; its upper nibble always reads 0.
   jtframe_dual_ram16 #(.aw(8), .hw(4)) u_pal (
      .clk   (clk),
      .addr0 (cpu.cpu_addr[7:0]),
      .data0 ({cpu.cpu_dout[3:0], cpu.cpu_dout}),
      .we0   (cpu_we),
      .q0    (cpu_q),
      .addr1 (idx_q[IDX_STAGES-1]),
      .ce1   (pxl_cen),
      .q1    (scan_q)
   );

   assign cpu.cpu_din = lane_q ? {4'h0, cpu_q[11:8]} : cpu_q[7:0];

   assign LHBL_dly = lhbl_q[BLANK_DLY-1];
   assign LVBL_dly = lvbl_q[BLANK_DLY-1];

   always_comb begin
      rgb = '0;
      if (LHBL_dly && LVBL_dly) begin
         rgb.red   = scan_q[3:0];
         rgb.green = scan_q[7:4];
         rgb.blue  = scan_q[11:8];
      end
   end

   assign red   = rgb.red;
   assign green = rgb.green;
   assign blue  = rgb.blue;

endmodule

// File: tb/tb_jtkunio_colmix.sv
// Directed-vector bench for jtkunio_colmix: priority, blanking, CPU port,
// pixel-enable stalls and mid-line reset.
module tb_jtkunio_colmix;

   logic       clk = 1'b0;
   logic       rst;
   logic       pxl_cen;
   logic       LHBL, LVBL;
   logic [5:0] scr_pxl;
   logic [6:0] obj_pxl;
   logic [1:0] gfx_en;
   logic [3:0] red, green, blue;
   logic       LHBL_dly, LVBL_dly;

   int compared   = 0;
   int mismatched = 0;

   jtkunio_colmix_if bus();

   jtkunio_colmix dut (
      .clk      (clk),
      .rst      (rst),
      .pxl_cen  (pxl_cen),
      .LHBL     (LHBL),
      .LVBL     (LVBL),
      .scr_pxl  (scr_pxl),
      .obj_pxl  (obj_pxl),
      .cpu      (bus),
      .gfx_en   (gfx_en),
      .red      (red),
      .green    (green),
      .blue     (blue),
      .LHBL_dly (LHBL_dly),
      .LVBL_dly (LVBL_dly)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  obj;
      logic [5:0]  scr;
      logic [1:0]  gfx;
      logic        lh;
      logic        lv;
      logic [11:0] rgb;   // expected {R,G,B} two pixels later
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input logic [11:0] exp_rgb,
                            input logic exp_lh, input logic exp_lv);
      check({name, " rgb"}, {red, green, blue}, exp_rgb);
      check({name, " LHBL_dly"}, {11'd0, LHBL_dly}, {11'd0, exp_lh});
      check({name, " LVBL_dly"}, {11'd0, LVBL_dly}, {11'd0, exp_lv});
   endtask

   // Entered and left on a falling edge; one pxl_cen pulse per call.
   task automatic pixel(input logic [6:0] o, input logic [5:0] s, input logic [1:0] g,
                        input logic lh, input logic lv);
      obj_pxl = o; scr_pxl = s; gfx_en = g; LHBL = lh; LVBL = lv;
      pxl_cen = 1'b1;
      @(negedge clk);
      pxl_cen = 1'b0;
      @(negedge clk);
   endtask

   task automatic cpu_wr(input logic [8:0] a, input logic [7:0] d);
      bus.cpu_addr = a; bus.cpu_dout = d; bus.pal_cs = 1'b1; bus.cpu_wrn = 1'b0;
      @(negedge clk);
      bus.pal_cs = 1'b0; bus.cpu_wrn = 1'b1;
      $display("cpu write addr=%h data=%h", a, d);
   endtask

   task automatic cpu_rd(input logic [8:0] a, input logic [7:0] exp);
      bus.cpu_addr = a; bus.pal_cs = 1'b1; bus.cpu_wrn = 1'b1;
      @(negedge clk);
      bus.pal_cs = 1'b0;
      $display("cpu read  addr=%h data=%h expect=%h", a, bus.cpu_din, exp);
      check("cpu readback", {4'h0, bus.cpu_din}, {4'h0, exp});
   endtask

   initial begin
      vecs[0]  = '{7'h05, 6'h09, 2'd3, 1'b1, 1'b1, 12'hA3C};
      vecs[1]  = '{7'h08, 6'h09, 2'd3, 1'b1, 1'b1, 12'h123};
      vecs[2]  = '{7'h08, 6'h09, 2'd2, 1'b1, 1'b1, 12'h564};
      vecs[3]  = '{7'h05, 6'h09, 2'd1, 1'b1, 1'b1, 12'h123};
      vecs[4]  = '{7'h00, 6'h00, 2'd3, 1'b1, 1'b1, 12'h564};
      vecs[5]  = '{7'h0F, 6'h3F, 2'd3, 1'b1, 1'b1, 12'h7E9};
      vecs[6]  = '{7'h00, 6'h3F, 2'd3, 1'b1, 1'b1, 12'hA57};
      vecs[7]  = '{7'h7F, 6'h00, 2'd3, 1'b1, 1'b1, 12'hDB1};
      vecs[8]  = '{7'h05, 6'h09, 2'd3, 1'b0, 1'b1, 12'h000};
      vecs[9]  = '{7'h05, 6'h09, 2'd3, 1'b0, 1'b1, 12'h000};
      vecs[10] = '{7'h05, 6'h09, 2'd3, 1'b0, 1'b1, 12'h000};
      vecs[11] = '{7'h05, 6'h09, 2'd3, 1'b1, 1'b1, 12'hA3C};
      vecs[12] = '{7'h0F, 6'h00, 2'd3, 1'b1, 1'b0, 12'h000};
      vecs[13] = '{7'h0F, 6'h00, 2'd3, 1'b1, 1'b1, 12'h7E9};
      vecs[14] = '{7'h7F, 6'h3F, 2'd0, 1'b1, 1'b1, 12'h564};
      vecs[15] = '{7'h00, 6'h3F, 2'd1, 1'b1, 1'b1, 12'hA57};
      vecs[16] = '{7'h08, 6'h00, 2'd3, 1'b1, 1'b1, 12'h564};

      rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
      scr_pxl = '0; obj_pxl = '0; gfx_en = 2'd3;
      bus.cpu_addr = '0; bus.pal_cs = 1'b0; bus.cpu_wrn = 1'b1; bus.cpu_dout = '0;
      repeat (3) @(negedge clk);
      check_out("reset state", 12'h000, 1'b0, 1'b0);
      rst = 1'b0;

      // Palette: lo lane {G,R}, hi lane {0,B}.
      cpu_wr(9'h085, 8'h3A); cpu_wr(9'h185, 8'h0C);
      cpu_wr(9'h009, 8'h21); cpu_wr(9'h109, 8'h03);
      cpu_wr(9'h000, 8'h65); cpu_wr(9'h100, 8'h04);
      cpu_wr(9'h08F, 8'hE7); cpu_wr(9'h18F, 8'h09);
      cpu_wr(9'h0FF, 8'hBD); cpu_wr(9'h1FF, 8'h01);
      cpu_wr(9'h03F, 8'h5A); cpu_wr(9'h13F, 8'hA7);
      cpu_rd(9'h03F, 8'h5A);
      cpu_rd(9'h13F, 8'h07);
      cpu_rd(9'h085, 8'h3A);
      cpu_rd(9'h185, 8'h0C);

      for (int i = 0; i <= NV; i++) begin
         int k;
         k = (i < NV) ? i : NV - 1;
         pixel(vecs[k].obj, vecs[k].scr, vecs[k].gfx, vecs[k].lh, vecs[k].lv);
         if (i == 0) begin
            $display("pixel 0: first after reset, rgb=%h", {red, green, blue});
            check_out("post-reset first pixel", 12'h000, 1'b0, 1'b0);
         end else begin
            $display("pixel %0d: obj=%h scr=%h gfx=%0d lh=%b lv=%b -> rgb=%h expect=%h",
                     i - 1, vecs[i-1].obj, vecs[i-1].scr, vecs[i-1].gfx,
                     vecs[i-1].lh, vecs[i-1].lv, {red, green, blue}, vecs[i-1].rgb);
            check_out($sformatf("vec%0d", i - 1), vecs[i-1].rgb, vecs[i-1].lh, vecs[i-1].lv);
         end
      end

      // Stall: outputs hold while pxl_cen is low, CPU writes still land.
      pixel(7'h05, 6'h09, 2'd3, 1'b1, 1'b1);
      pixel(7'h0F, 6'h00, 2'd3, 1'b1, 1'b1);
      check_out("pre-stall", 12'hA3C, 1'b1, 1'b1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check_out($sformatf("stall clk%0d", c), 12'hA3C, 1'b1, 1'b1);
      end
      cpu_wr(9'h040, 8'h99);
      cpu_rd(9'h040, 8'h99);
      check_out("stall after cpu", 12'hA3C, 1'b1, 1'b1);
      pixel(7'h7F, 6'h00, 2'd3, 1'b1, 1'b1);
      $display("resume 0: rgb=%h", {red, green, blue});
      check_out("resume 0", 12'h7E9, 1'b1, 1'b1);
      pixel(7'h00, 6'h00, 2'd3, 1'b1, 1'b1);
      $display("resume 1: rgb=%h", {red, green, blue});
      check_out("resume 1", 12'hDB1, 1'b1, 1'b1);
      pixel(7'h00, 6'h00, 2'd3, 1'b1, 1'b1);
      $display("resume 2: rgb=%h", {red, green, blue});
      check_out("resume 2", 12'h564, 1'b1, 1'b1);

      // Mid-line reset.
      pixel(7'h05, 6'h09, 2'd3, 1'b1, 1'b1);
      pixel(7'h05, 6'h09, 2'd3, 1'b1, 1'b1);
      check_out("pre-reset", 12'hA3C, 1'b1, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      $display("mid-line reset: rgb=%h", {red, green, blue});
      check_out("mid-line reset", 12'h000, 1'b0, 1'b0);
      pixel(7'h0F, 6'h00, 2'd3, 1'b1, 1'b1);
      check_out("reset +1 pixel", 12'h000, 1'b0, 1'b0);
      pixel(7'h0F, 6'h00, 2'd3, 1'b1, 1'b1);
      $display("reset +2 pixel: rgb=%h", {red, green, blue});
      check_out("reset +2 pixel", 12'h7E9, 1'b1, 1'b1);
      cpu_rd(9'h085, 8'h3A);
      cpu_rd(9'h185, 8'h0C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
